// File: rtl/riscv_state_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_state_pkg
// Brief    : Shared types for the instruction-fetch prefetch buffer.
// Revision : 1.0
// ============================================================================
package riscv_state_pkg;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] parcel;
        logic [31:0] pc;
        logic        misaligned;
        logic        fault;
    } if_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } if_pf_state_t;

endpackage
`default_nettype wire

// File: rtl/riscv_if_fifo.sv
`default_nettype none
// ============================================================================
// Module   : riscv_if_fifo
// Brief    : DEPTH-entry queue of fetched parcels; clr may coincide with push.
// Revision : 1.0
// ============================================================================
module riscv_if_fifo
    import riscv_state_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clr,
    input  if_entry_t              din,
    output if_entry_t              dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    if_entry_t     mem [DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            // a push on the clearing cycle becomes the first entry of the new path
            rd_ptr <= '0;
            wr_ptr <= push ? AW'(1) : '0;
            count  <= push ? (AW+1)'(1) : '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[clr ? '0 : wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/riscv_if_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : riscv_if_prefetch
// Brief    : Single-outstanding instruction prefetch buffer with flush/discard.
//            Define IF_PREFETCH_BYPASS_EN for zero-latency bypass when empty.
// Revision : 1.0
// ============================================================================
module riscv_if_prefetch
    import riscv_state_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter int          PARCEL_SIZE = 32,
    parameter int          DEPTH       = 2,
    parameter logic [31:0] INSTR_NOP   = riscv_state_pkg::INSTR_NOP
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [XLEN-1:0]           if_nxt_pc,
    output logic                      if_stall_nxt_pc,
    input  logic                      if_stall,
    input  logic                      if_flush,
    output logic [PARCEL_SIZE-1:0]    if_parcel,
    output logic [XLEN-1:0]           if_parcel_pc,
    output logic [PARCEL_SIZE/16-1:0] if_parcel_valid,
    output logic                      if_parcel_misaligned,
    output logic                      if_parcel_page_fault,
    output logic                      imem_req,
    output logic [XLEN-1:0]           imem_adr,
    input  logic                      imem_ack,
    input  logic [PARCEL_SIZE-1:0]    imem_q,
    input  logic                      imem_err,
    input  logic                      imem_page_fault
);

    localparam int CW = $clog2(DEPTH) + 1;

    if_pf_state_t  state;
    logic          run;
    logic [XLEN-1:0] adr_r;
    logic [XLEN-1:0] pc_r;

    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          inflight;
    logic          credit;
    logic          accept;
    logic          misaligned;
    logic          issue;
    logic          ack_push;
    logic          push_req;
    logic          fifo_push;
    logic          pop;
    logic          bypass;
    if_entry_t     new_entry;
    if_entry_t     head;
    if_entry_t     out_entry;

    assign inflight   = (state == WAIT);
    assign credit     = (count + CW'(inflight)) < CW'(DEPTH);
    assign accept     = (state == IDLE) && credit && run;
    assign misaligned = |if_nxt_pc[1:0];
    assign issue      = accept && !misaligned;

    assign if_stall_nxt_pc = !accept;
    assign imem_req        = issue || (state != IDLE);
    assign imem_adr        = issue ? {if_nxt_pc[XLEN-1:2], 2'b00} : adr_r;

    // an ack while flushing in WAIT (or any ack in DISCARD) is dropped
    assign ack_push = imem_ack && (issue || (state == WAIT && !if_flush));
    assign push_req = (accept && misaligned) || ack_push;

    always_comb begin
        new_entry.parcel     = imem_q;
        new_entry.pc         = (state == IDLE) ? if_nxt_pc : pc_r;
        new_entry.misaligned = 1'b0;
        new_entry.fault      = imem_err | imem_page_fault;
        if (accept && misaligned) begin
            new_entry.parcel     = INSTR_NOP;
            new_entry.pc         = if_nxt_pc;
            new_entry.misaligned = 1'b1;
            new_entry.fault      = 1'b0;
        end
    end

`ifdef IF_PREFETCH_BYPASS_EN
    assign bypass = ack_push && empty && !if_stall && !if_flush;
`else
    assign bypass = 1'b0;
`endif

    assign pop       = !empty && !if_flush && !if_stall;
    assign fifo_push = push_req && !bypass && (!full || pop);

    riscv_if_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (fifo_push),
        .pop   (pop),
        .clr   (if_flush),
        .din   (new_entry),
        .dout  (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    always_comb begin
        if (bypass) begin
            out_entry = new_entry;
        end else if (empty) begin
            out_entry = '{parcel: INSTR_NOP, pc: '0, misaligned: 1'b0, fault: 1'b0};
        end else begin
            out_entry = head;
        end
    end

    assign if_parcel            = out_entry.parcel;
    assign if_parcel_pc         = out_entry.pc;
    assign if_parcel_misaligned = out_entry.misaligned;
    assign if_parcel_page_fault = out_entry.fault;
    assign if_parcel_valid      = {(PARCEL_SIZE/16){(!empty && !if_flush) || bypass}};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            run   <= 1'b0;
            adr_r <= '0;
            pc_r  <= '0;
        end else begin
            run <= 1'b1;
            case (state)
                IDLE: begin
                    if (issue && !imem_ack) begin
                        state <= WAIT;
                        adr_r <= {if_nxt_pc[XLEN-1:2], 2'b00};
                        pc_r  <= if_nxt_pc;
                    end
                end
                WAIT: begin
                    // an ack on the flush cycle already closes the request
                    if (imem_ack)      state <= IDLE;
                    else if (if_flush) state <= DISCARD;
                end
                DISCARD: begin
                    if (imem_ack) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_if_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_if_prefetch
// Brief    : Scoreboard bench for riscv_if_prefetch with a delay-programmable memory.
// Revision : 1.0
// ============================================================================
module tb_riscv_if_prefetch;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] ERR_ADR = 32'h0000_0300;

    typedef struct {
        logic [31:0] parcel;
        logic [31:0] pc;
        logic        mis;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] if_nxt_pc = 32'h200;
    logic        if_stall_nxt_pc;
    logic        if_stall = 1'b0;
    logic        if_flush = 1'b0;
    logic [31:0] if_parcel;
    logic [31:0] if_parcel_pc;
    logic [1:0]  if_parcel_valid;
    logic        if_parcel_misaligned;
    logic        if_parcel_page_fault;
    logic        imem_req;
    logic [31:0] imem_adr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_q = '0;
    logic        imem_err = 1'b0;
    logic        imem_page_fault = 1'b0;

    int total = 0;
    int bad   = 0;
    int mem_delay = 0;
    int mem_wait  = 0;
    exp_t sb[$];

    logic        s_stall_nxt, s_req, s_mis, s_fault;
    logic [1:0]  s_valid;
    logic [31:0] s_parcel, s_pc, s_adr;

    riscv_if_prefetch dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .if_nxt_pc            (if_nxt_pc),
        .if_stall_nxt_pc      (if_stall_nxt_pc),
        .if_stall             (if_stall),
        .if_flush             (if_flush),
        .if_parcel            (if_parcel),
        .if_parcel_pc         (if_parcel_pc),
        .if_parcel_valid      (if_parcel_valid),
        .if_parcel_misaligned (if_parcel_misaligned),
        .if_parcel_page_fault (if_parcel_page_fault),
        .imem_req             (imem_req),
        .imem_adr             (imem_adr),
        .imem_ack             (imem_ack),
        .imem_q               (imem_q),
        .imem_err             (imem_err),
        .imem_page_fault      (imem_page_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h500) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic exp_t expect_for(input logic [31:0] pc);
        exp_t        e;
        logic [31:0] al;
        al = {pc[31:2], 2'b00};
        if (pc[1:0] != 2'b00) begin
            e.parcel = NOP; e.pc = pc; e.mis = 1'b1; e.fault = 1'b0;
        end else begin
            e.parcel = mem_data(al); e.pc = pc; e.mis = 1'b0; e.fault = (al == ERR_ADR);
        end
        return e;
    endfunction

    // one cycle: inputs set at edge+1, memory answers at +2, snapshot at +3
    task automatic step();
        #1;
        if (imem_req && mem_wait >= mem_delay) begin
            imem_ack = 1'b1;
            imem_q   = mem_data(imem_adr);
            imem_err = (imem_adr == ERR_ADR);
        end else begin
            imem_ack = 1'b0;
            imem_q   = '0;
            imem_err = 1'b0;
        end
        #1;
        s_stall_nxt = if_stall_nxt_pc;
        s_req       = imem_req;
        s_adr       = imem_adr;
        s_valid     = if_parcel_valid;
        s_parcel    = if_parcel;
        s_pc        = if_parcel_pc;
        s_mis       = if_parcel_misaligned;
        s_fault     = if_parcel_page_fault;
        @(posedge clk);
        #1;
        if (imem_ack) mem_wait = 0;
        else if (s_req) mem_wait++;
        imem_ack = 1'b0;
        imem_err = 1'b0;
        if (!s_stall_nxt) if_nxt_pc = if_nxt_pc + 32'd4;
    endtask

    // scoreboard: push on accepted PC, pop/compare on consumed parcel
    always @(negedge clk) begin
        if (!rstn) begin
            sb.delete();
        end else begin
            total++;
            if (if_parcel_valid != 2'b00 && if_parcel_valid != 2'b11) begin
                bad++;
                $display("FAIL valid_bits: got %b want 00 or 11", if_parcel_valid);
            end
            if (if_flush) begin
                sb.delete();
            end else if (if_parcel_valid == 2'b11 && !if_stall) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_spurious: got pc=%h parcel=%h, want no valid parcel", if_parcel_pc, if_parcel);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (if_parcel !== e.parcel || if_parcel_pc !== e.pc ||
                        if_parcel_misaligned !== e.mis || if_parcel_page_fault !== e.fault) begin
                        bad++;
                        $display("FAIL sb_entry: got parcel=%h pc=%h mis=%b flt=%b, want parcel=%h pc=%h mis=%b flt=%b",
                                 if_parcel, if_parcel_pc, if_parcel_misaligned, if_parcel_page_fault,
                                 e.parcel, e.pc, e.mis, e.fault);
                    end
                end
            end
            if (!if_stall_nxt_pc) sb.push_back(expect_for(if_nxt_pc));
        end
    end

    task automatic test_reset();
        #7;
        total++;
        if (imem_req !== 1'b0 || imem_adr !== 32'h0 || if_stall_nxt_pc !== 1'b1 || if_parcel_valid !== 2'b00) begin
            bad++;
            $display("FAIL reset_ctrl: got req=%b adr=%h stall_nxt=%b valid=%b, want 0 0 1 00",
                     imem_req, imem_adr, if_stall_nxt_pc, if_parcel_valid);
        end
        total++;
        if (if_parcel !== NOP || if_parcel_pc !== 32'h0 || if_parcel_misaligned !== 1'b0 || if_parcel_page_fault !== 1'b0) begin
            bad++;
            $display("FAIL reset_head: got parcel=%h pc=%h mis=%b flt=%b, want %h 0 0 0",
                     if_parcel, if_parcel_pc, if_parcel_misaligned, if_parcel_page_fault, NOP);
        end
        @(posedge clk);
        #1;
        if_nxt_pc = 32'h200;
        rstn = 1'b1;
        step();
        total++;
        if (s_stall_nxt !== 1'b1 || s_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_run: got stall_nxt=%b req=%b, want 1 0", s_stall_nxt, s_req);
        end
    endtask

    task automatic test_throughput();
        step();
        total++;
        if (s_req !== 1'b1 || s_adr !== 32'h200 || s_stall_nxt !== 1'b0) begin
            bad++;
            $display("FAIL tp_first_req: got req=%b adr=%h stall_nxt=%b, want 1 200 0", s_req, s_adr, s_stall_nxt);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            total++;
            if (s_valid !== 2'b11 || s_pc !== 32'h200 + 32'(4 * i) || s_parcel !== mem_data(32'h200 + 32'(4 * i))) begin
                bad++;
                $display("FAIL tp_cycle%0d: got valid=%b pc=%h parcel=%h, want 11 %h %h", i, s_valid, s_pc, s_parcel,
                         32'h200 + 32'(4 * i), mem_data(32'h200 + 32'(4 * i)));
            end
        end
    endtask

    task automatic test_stall();
        if_stall  = 1'b1;
        if_flush  = 1'b1;
        if_nxt_pc = 32'h200;
        step();
        if_flush = 1'b0;
        total++;
        if (s_stall_nxt !== 1'b0) begin
            bad++;
            $display("FAIL stall_push1: got stall_nxt=%b want 0", s_stall_nxt);
        end
        step();
        total++;
        if (s_stall_nxt !== 1'b0 || s_pc !== 32'h200) begin
            bad++;
            $display("FAIL stall_push2: got stall_nxt=%b pc=%h want 0 200", s_stall_nxt, s_pc);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (s_stall_nxt !== 1'b1 || s_req !== 1'b0 || s_pc !== 32'h200 || s_valid !== 2'b11) begin
                bad++;
                $display("FAIL stall_hold%0d: got stall_nxt=%b req=%b pc=%h valid=%b, want 1 0 200 11",
                         i, s_stall_nxt, s_req, s_pc, s_valid);
            end
        end
        if_stall = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_flush_wait();
        bit found = 1'b0;
        mem_delay = 3;
        if_nxt_pc = 32'h500;
        step();
        total++;
        if (s_req !== 1'b1 || s_adr !== 32'h500 || s_stall_nxt !== 1'b0) begin
            bad++;
            $display("FAIL fl_req: got req=%b adr=%h stall_nxt=%b want 1 500 0", s_req, s_adr, s_stall_nxt);
        end
        step();
        if_flush  = 1'b1;
        if_nxt_pc = 32'h400;
        step();
        if_flush = 1'b0;
        step();
        total++;
        if (s_stall_nxt !== 1'b1 || s_req !== 1'b1) begin
            bad++;
            $display("FAIL fl_discard: got stall_nxt=%b req=%b want 1 1", s_stall_nxt, s_req);
        end
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (s_valid == 2'b11) begin
                found = 1'b1;
                total++;
                if (s_pc !== 32'h400 || s_parcel !== mem_data(32'h400) || i != 4) begin
                    bad++;
                    $display("FAIL fl_newpath: got pc=%h parcel=%h at cycle %0d, want 400 %h at cycle 4",
                             s_pc, s_parcel, i, mem_data(32'h400));
                end
            end
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL fl_timeout: got no valid parcel in 20 cycles, want pc 400");
        end
    endtask

    task automatic test_misaligned();
        mem_delay = 0;
        repeat (5) step();
        if_nxt_pc = 32'h202;
        step();
        total++;
        if (s_req !== 1'b0 || s_stall_nxt !== 1'b0) begin
            bad++;
            $display("FAIL mis_noreq: got req=%b stall_nxt=%b want 0 0", s_req, s_stall_nxt);
        end
        if_nxt_pc = 32'h208;
        step();
        total++;
        if (s_valid !== 2'b11 || s_parcel !== NOP || s_mis !== 1'b1 || s_pc !== 32'h202) begin
            bad++;
            $display("FAIL mis_entry: got valid=%b parcel=%h mis=%b pc=%h want 11 %h 1 202",
                     s_valid, s_parcel, s_mis, s_pc, NOP);
        end
    endtask

    task automatic test_error();
        repeat (2) step();
        if_nxt_pc = 32'h300;
        step();
        step();
        total++;
        if (s_valid !== 2'b11 || s_pc !== 32'h300 || s_fault !== 1'b1) begin
            bad++;
            $display("FAIL err_entry: got valid=%b pc=%h fault=%b want 11 300 1", s_valid, s_pc, s_fault);
        end
        step();
        total++;
        if (s_valid !== 2'b11 || s_pc !== 32'h304 || s_fault !== 1'b0) begin
            bad++;
            $display("FAIL err_next: got valid=%b pc=%h fault=%b want 11 304 0", s_valid, s_pc, s_fault);
        end
    endtask

    task automatic test_reset_in_wait();
        mem_delay = 5;
        if_nxt_pc = 32'h600;
        step();
        step();
        total++;
        if (s_req !== 1'b1 || s_adr !== 32'h600) begin
            bad++;
            $display("FAIL rw_hold: got req=%b adr=%h want 1 600", s_req, s_adr);
        end
        rstn = 1'b0;
        #1;
        total++;
        if (imem_req !== 1'b0 || imem_adr !== 32'h0 || if_stall_nxt_pc !== 1'b1 || if_parcel_valid !== 2'b00) begin
            bad++;
            $display("FAIL rw_ctrl: got req=%b adr=%h stall_nxt=%b valid=%b want 0 0 1 00",
                     imem_req, imem_adr, if_stall_nxt_pc, if_parcel_valid);
        end
        total++;
        if (if_parcel !== NOP || if_parcel_pc !== 32'h0 || if_parcel_misaligned !== 1'b0 || if_parcel_page_fault !== 1'b0) begin
            bad++;
            $display("FAIL rw_head: got parcel=%h pc=%h mis=%b flt=%b want %h 0 0 0",
                     if_parcel, if_parcel_pc, if_parcel_misaligned, if_parcel_page_fault, NOP);
        end
        mem_wait  = 0;
        mem_delay = 0;
        repeat (2) step();
        rstn = 1'b1;
        step();
        total++;
        if (s_stall_nxt !== 1'b1) begin
            bad++;
            $display("FAIL rw_run: got stall_nxt=%b want 1", s_stall_nxt);
        end
        step();
        total++;
        if (s_stall_nxt !== 1'b0 || s_req !== 1'b1) begin
            bad++;
            $display("FAIL rw_restart: got stall_nxt=%b req=%b want 0 1", s_stall_nxt, s_req);
        end
        repeat (4) step();
    endtask

    initial begin
        test_reset();
        test_throughput();
        test_stall();
        test_flush_wait();
        test_misaligned();
        test_error();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
